dac_port_tx: RTL and testbench

//  Transmit-side counterpart of the dual 14-bit ADC capture path: drives a dual-channel 14-bit

---
 rtl/dac_pkg.sv | 25 ++
 rtl/dac_sample_fifo.sv | 74 +++++++
 rtl/dac_port_tx.sv | 160 ++++++++++++++++
 tb/tb_dac_port_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared FSM encoding and sample-format helpers for the DAC transmit path.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAKE  = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int DW_DEFAULT = 14;

    // Mid-code of a dw-bit offset-binary converter (zero analogue output)
    function automatic logic [31:0] midscale(input int dw);
        return 32'd1 << (dw - 1);
    endfunction

    // Two's complement to offset binary is a sign-bit inversion
    function automatic logic [31:0] to_offset_bin(input logic [31:0] s, input int dw);
        return s ^ midscale(dw);
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample-pair FIFO with flush, occupancy level and look-ahead full flag.
// Latency: pushed word visible at head the cycle after the push; head read is combinational.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over push/pop.
module dac_sample_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full_nxt,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Occupancy after this cycle; simultaneous push and pop leave it unchanged
    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_nxt = level - 1'b1;
        end
    end

    assign full_nxt = (level_nxt == LW'(DEPTH));

    // Pointers wrap naturally at DEPTH (power of two); flush realigns them
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
        end
    end

    // Storage array needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dac_port_tx.sv
// Dual-channel DAC data/sleep driver fed from a buffered valid/ready sample stream; optional DAC_UNDERRUN_CNT_EN adds underrun_cnt.
// Latency: sample at FIFO head on an update tick reaches da_port*_data one cycle later.
// Backpressure: s_ready is a registered not-full flag; an empty FIFO on a tick holds outputs and pulses underrun.
module dac_port_tx
    import dac_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int WAKE_CYCLES = 64,
    parameter int DIV         = 1,
    parameter int TWOS_IN     = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          en,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data_a,
    input  logic [DW-1:0] s_data_b,
    output logic [DW-1:0] da_porta_data,
    output logic [DW-1:0] da_portb_data,
    output logic          da_sleep,
    output logic          running,
    output logic          underrun
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(WAKE_CYCLES) + 1;
    localparam logic [DW-1:0] MID = DW'(midscale(DW));

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   wake_cnt;
    logic [7:0]      div_cnt;
    logic            flush;
    logic            push;
    logic            tick;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full_nxt;
    logic [LW-1:0]   fifo_level;
    logic [2*DW-1:0] head;
    logic [DW-1:0]   head_a;
    logic [DW-1:0]   head_b;
    logic [DW-1:0]   conv_a;
    logic [DW-1:0]   conv_b;

    // Dropping en discards everything buffered so a restart never plays stale samples
    assign flush    = !en;
    assign push     = s_valid && s_ready;
    assign tick     = !sys_rst && en && (state == RUN) && (div_cnt == 8'(DIV - 1));
    assign pop      = tick && !fifo_empty;
    // No fall-through: a sample pushed in the tick cycle is not yet visible
    assign underrun = tick && fifo_empty;
    assign da_sleep = (state == IDLE);
    assign running  = (state == RUN);

    assign head_a = head[2*DW-1:DW];
    assign head_b = head[DW-1:0];
    assign conv_a = (TWOS_IN != 0) ? DW'(to_offset_bin(32'(head_a), DW)) : head_a;
    assign conv_b = (TWOS_IN != 0) ? DW'(to_offset_bin(32'(head_b), DW)) : head_b;

    dac_sample_fifo #(
        .W     (2 * DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .flush    (flush),
        .push     (push),
        .wdata    ({s_data_a, s_data_b}),
        .pop      (pop),
        .rdata    (head),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt),
        .level    (fifo_level)
    );

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sleep/wake sequencing; en low returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = WAKE;
                WAKE:    if (wake_cnt == WW'(WAKE_CYCLES - 1)) state_nxt = PRIME;
                PRIME:   if (fifo_level >= LW'(PRIME_LEVEL)) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counts cycles since the DAC was released from sleep
    always_ff @(posedge sys_clk) begin
        if (sys_rst || state != WAKE) begin
            wake_cnt <= '0;
        end else begin
            wake_cnt <= wake_cnt + 1'b1;
        end
    end

    // Update-rate divider, free-running only while in RUN
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !en || state != RUN) begin
            div_cnt <= '0;
        end else if (div_cnt == 8'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // DAC data registers: midscale when idle, new pair on each successful tick
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !en) begin
            da_porta_data <= MID;
            da_portb_data <= MID;
        end else if (pop) begin
            da_porta_data <= conv_a;
            da_portb_data <= conv_b;
        end
    end

    // Ready is low through reset, then tracks the FIFO's next-cycle full flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= !fifo_full_nxt;
        end
    end

`ifdef DAC_UNDERRUN_CNT_EN
    // Saturating underrun tally; survives en toggles, cleared only by reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            underrun_cnt <= '0;
        end else if (underrun && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_port_tx.sv
// Bench for dac_port_tx: two instances (DIV=1, DIV=4) share stimulus and are compared each cycle to a queue model.
// Latency: model predicts outputs one cycle after each update tick.
// Backpressure: model tracks its own ready flag and only enqueues pairs it accepts.
module tb_dac_port_tx;

    localparam int DEPTH = 8;
    localparam int PRIME = 4;
    localparam int WAKE  = 64;
    localparam logic [13:0] MID = 14'h2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sv;
    logic [13:0] da;
    logic [13:0] db;
    logic        rdy [2];
    logic [13:0] pa  [2];
    logic [13:0] pb  [2];
    logic        slp [2];
    logic        run [2];
    logic        ur  [2];
`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0] ucnt  [2];
    logic [15:0] m_cnt [2];
`endif

    // Reference model state, one slot per instance
    logic [27:0] m_q [2][$];
    int          m_awake [2];
    int          m_div   [2];
    bit          m_run   [2];
    bit          m_rdy   [2];
    bit          m_ur    [2];
    logic [13:0] m_a     [2];
    logic [13:0] m_b     [2];
    logic        obs_ur  [2];
    int          n_acc   [2];
    int          divs    [2] = '{1, 4};

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    dac_port_tx #(.DW(14), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .WAKE_CYCLES(WAKE),
                  .DIV(1), .TWOS_IN(1)) u_div1 (
        .sys_clk(clk), .sys_rst(rst), .en(en), .s_valid(sv), .s_ready(rdy[0]),
        .s_data_a(da), .s_data_b(db), .da_porta_data(pa[0]), .da_portb_data(pb[0]),
        .da_sleep(slp[0]), .running(run[0]), .underrun(ur[0])
`ifdef DAC_UNDERRUN_CNT_EN
        , .underrun_cnt(ucnt[0])
`endif
    );

    dac_port_tx #(.DW(14), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .WAKE_CYCLES(WAKE),
                  .DIV(4), .TWOS_IN(1)) u_div4 (
        .sys_clk(clk), .sys_rst(rst), .en(en), .s_valid(sv), .s_ready(rdy[1]),
        .s_data_a(da), .s_data_b(db), .da_porta_data(pa[1]), .da_portb_data(pb[1]),
        .da_sleep(slp[1]), .running(run[1]), .underrun(ur[1])
`ifdef DAC_UNDERRUN_CNT_EN
        , .underrun_cnt(ucnt[1])
`endif
    );

    // Two's complement code to offset-binary DAC code: shift the range up by half scale
    function automatic logic [13:0] to_dac(input logic [13:0] x);
        int v;
        v = (int'(x) + 8192) % 16384;
        return v[13:0];
    endfunction

    function automatic logic [31:0] obs_vec(input int d);
        return {pa[d], pb[d], slp[d], run[d], rdy[d], obs_ur[d]};
    endfunction

    function automatic logic [31:0] exp_vec(input int d);
        return {m_a[d], m_b[d], (m_awake[d] == 0), m_run[d], m_rdy[d], m_ur[d]};
    endfunction

    // One clock: sample the combinational underrun, advance the model, then the DUT
    task automatic step();
        bit          acc;
        bit          tk;
        int          lvl;
        logic [27:0] p;
        #1;
        for (int d = 0; d < 2; d++) begin
            obs_ur[d] = ur[d];
            m_ur[d] = !rst && en && m_run[d] && (m_div[d] == divs[d] - 1) && (m_q[d].size() == 0);
            acc = sv && m_rdy[d];
`ifdef DAC_UNDERRUN_CNT_EN
            if (rst) m_cnt[d] = 16'h0;
            else if (m_ur[d] && m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'h1;
`endif
            if (rst || !en) begin
                m_q[d].delete();
                m_awake[d] = 0;
                m_run[d]   = 1'b0;
                m_div[d]   = 0;
                m_a[d]     = MID;
                m_b[d]     = MID;
                m_rdy[d]   = !rst;
            end else begin
                lvl = m_q[d].size();
                tk  = m_run[d] && (m_div[d] == divs[d] - 1);
                if (tk && lvl > 0) begin
                    p = m_q[d].pop_front();
                    m_a[d] = to_dac(p[27:14]);
                    m_b[d] = to_dac(p[13:0]);
                end
                if (acc) begin
                    m_q[d].push_back({da, db});
                    n_acc[d]++;
                end
                if (m_run[d]) m_div[d] = tk ? 0 : m_div[d] + 1;
                else if (m_awake[d] > WAKE && lvl >= PRIME) m_run[d] = 1'b1;
                if (m_awake[d] <= WAKE) m_awake[d]++;
                m_rdy[d] = (m_q[d].size() != DEPTH);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sv = 1'b0; da = '0; db = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rst = 1'b0;
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc %0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        n_chk++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready cyc %0d: got %b want 1", cyc, rdy[0]);
        end
`ifdef DAC_UNDERRUN_CNT_EN
        n_chk++;
        if (ucnt[0] !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0", ucnt[0]);
        end
`endif
    endtask

    // Wake sequencing, FIFO filling during WAKE, first converted output
    task automatic test_wake_fill();
        en = 1'b1; sv = 1'b1; da = 14'h1FFF; db = 14'h2000;
        n_acc[0] = 0;
        for (int c = 1; c <= 70; c++) begin
            if (n_acc[0] >= 8) begin
                da = 14'($urandom);
                db = 14'($urandom);
            end
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL wake dut%0d cyc %0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (c == 1) begin
                n_chk++;
                if (slp[0] !== 1'b0) begin n_fail++; $display("FAIL sleep_release: got %b want 0", slp[0]); end
            end
            if (c == 8) begin
                n_chk++;
                if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", rdy[0]); end
            end
            if (c == 65) begin
                n_chk++;
                if (run[0] !== 1'b0) begin n_fail++; $display("FAIL early_run: got %b want 0", run[0]); end
            end
            if (c == 66) begin
                n_chk++;
                if (run[0] !== 1'b1) begin n_fail++; $display("FAIL run_entry: got %b want 1", run[0]); end
            end
            if (c == 67) begin
                n_chk++;
                if (pa[0] !== 14'h3FFF || pb[0] !== 14'h0000) begin
                    n_fail++;
                    $display("FAIL first_out: got %h/%h want 3fff/0000", pa[0], pb[0]);
                end
            end
        end
    endtask

    // Starve both instances; underrun pulses at each update tick, outputs hold
    task automatic test_underrun();
        int nur [2];
        sv = 1'b0;
        nur[0] = 0; nur[1] = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL underrun dut%0d cyc %0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
                end
                if (i >= 38 && obs_ur[d] === 1'b1) nur[d]++;
            end
        end
        n_chk++;
        if (nur[0] != 12) begin n_fail++; $display("FAIL ur_rate_div1: got %0d want 12", nur[0]); end
        n_chk++;
        if (nur[1] != 3) begin n_fail++; $display("FAIL ur_rate_div4: got %0d want 3", nur[1]); end
    endtask

    // Continuous ramp into the DIV=4 instance: one step every 4 cycles, no skips
    task automatic test_div4_stream();
        logic [13:0] r;
        logic [13:0] prev;
        int          last_chg;
        bit          acc1;
        r = 14'd0; prev = pa[1]; last_chg = -1; sv = 1'b1;
        for (int i = 0; i < 80; i++) begin
            da = r; db = ~r;
            acc1 = m_rdy[1];
            step();
            if (acc1) r = r + 14'd1;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL stream dut%0d cyc %0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (pa[1] !== prev) begin
                if (last_chg >= 0) begin
                    n_chk++;
                    if (i - last_chg != 4) begin n_fail++; $display("FAIL div4_gap: got %0d want 4", i - last_chg); end
                    n_chk++;
                    if (14'(pa[1] - prev) !== 14'd1) begin
                        n_fail++;
                        $display("FAIL div4_ramp: got %h after %h want step 1", pa[1], prev);
                    end
                end
                last_chg = i;
                prev = pa[1];
            end
            if (i >= 8) begin
                n_chk++;
                if (obs_ur[1] !== 1'b0) begin n_fail++; $display("FAIL div4_underrun cyc %0d: got 1 want 0", cyc); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            sv = ($urandom_range(0, 3) != 0);
            da = 14'($urandom);
            db = 14'($urandom);
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc %0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
`ifdef DAC_UNDERRUN_CNT_EN
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (ucnt[d] !== m_cnt[d]) begin n_fail++; $display("FAIL cnt dut%0d: got %0d want %0d", d, ucnt[d], m_cnt[d]); end
        end
`endif
    endtask

    // Drop en with samples queued; restart must only play new samples
    task automatic test_en_drop();
        sv = 1'b1;
        for (int i = 0; i < 40 && m_q[1].size() < 5; i++) begin
            da = 14'($urandom);
            db = 14'($urandom);
            step();
        end
        en = 1'b0;
        for (int i = 0; i < 94; i++) begin
            if (i == 4) en = 1'b1;
            sv = (i < 2) || ($urandom_range(0, 1) != 0);
            da = 14'($urandom);
            db = 14'($urandom);
            step();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL en_drop dut%0d cyc %0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (i == 0) begin
                n_chk++;
                if (pa[1] !== MID || slp[1] !== 1'b1 || run[1] !== 1'b0 || rdy[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL idle_return: got %h sleep %b run %b rdy %b want 2000 1 0 1", pa[1], slp[1], run[1], rdy[1]);
                end
`ifdef DAC_UNDERRUN_CNT_EN
                for (int d = 0; d < 2; d++) begin
                    n_chk++;
                    if (ucnt[d] !== m_cnt[d]) begin
                        n_fail++;
                        $display("FAIL cnt_retain dut%0d: got %0d want %0d", d, ucnt[d], m_cnt[d]);
                    end
                end
`endif
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_awake[d] = 0; m_div[d] = 0; m_run[d] = 1'b0; m_rdy[d] = 1'b0; m_ur[d] = 1'b0;
            m_a[d] = MID; m_b[d] = MID; n_acc[d] = 0;
`ifdef DAC_UNDERRUN_CNT_EN
            m_cnt[d] = 16'h0;
`endif
        end
        test_reset();
        test_wake_fill();
        test_underrun();
        test_div4_stream();
        test_random();
        test_en_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
